// File: rtl/shift_sequencer.sv
// Bit-serial shifter sequencer: one shift/rotate step per clock with ARM-style carry-out.
// Define SHIFT_SEQ_DUAL_STEP_EN to retire two steps per clock while two or more remain.
module shift_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] din,
  input  logic [4:0]   shamt,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] dout,
  output logic         cout
);

  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_RRX = 3'b110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t       state, next_state;
  logic [N-1:0] work;
  logic [4:0]   count;
  logic [2:0]   op_q;
  logic         cin_q;

  logic         accept, is_pass, direct, last;
  logic [N:0]   first, second;
  logic [4:0]   dec;

  // Returns {carry_out, shifted_word} for a single one-bit step.
  function automatic logic [N:0] step_one(input logic [2:0] o, input logic [N-1:0] v,
                                          input logic fill);
    case (o)
      OP_LSL:  step_one = {v[N-1], v[N-2:0], 1'b0};
      OP_LSR:  step_one = {v[0], 1'b0, v[N-1:1]};
      OP_ASR:  step_one = {v[0], v[N-1], v[N-1:1]};
      OP_ROR:  step_one = {v[0], v[0], v[N-1:1]};
      default: step_one = {v[0], fill, v[N-1:1]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    ready      = (state != SHIFT);
    busy       = (state == SHIFT);
    done       = (state == DONE);
    accept     = ready && start;
    is_pass    = !(op == OP_LSL || op == OP_LSR || op == OP_ASR ||
                   op == OP_ROR || op == OP_RRX);
    direct     = is_pass || (shamt == 5'd0 && op != OP_RRX);
    first      = step_one(op_q, work, cin_q);
    second     = first;
    dec        = 5'd1;
    last       = (count == 5'd1);
`ifdef SHIFT_SEQ_DUAL_STEP_EN
    if (count >= 5'd2) begin
      second = step_one(op_q, first[N-1:0], cin_q);
      dec    = 5'd2;
    end
    last = (count <= 5'd2);
`endif
    next_state = state;
    case (state)
      SHIFT:   if (last) next_state = DONE;
      default: begin
        if (accept) next_state = direct ? DONE : SHIFT;
        else        next_state = IDLE;
      end
    endcase
  end

  // Operands are latched only on acceptance, so starts during SHIFT cannot disturb them.
  always_ff @(posedge clk) begin
    if (reset) begin
      work  <= '0;
      count <= '0;
      op_q  <= '0;
      cin_q <= 1'b0;
      dout  <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      cin_q <= cin;
      work  <= din;
      count <= (op == OP_RRX) ? 5'd1 : shamt;
      if (direct) begin
        dout <= din;
        cout <= cin;
      end
    end else if (state == SHIFT) begin
      work  <= second[N-1:0];
      count <= count - dec;
      if (last) begin
        dout <= second[N-1:0];
        cout <= second[N];
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed test-plan cases plus random ops,
// with expected results queued at stimulus time and compared when done pulses.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic        cin;
  logic        ready, busy, done;
  logic [31:0] dout;
  logic        cout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        c;
    int          lat;
  } exp_t;

  exp_t sb[$];

  shift_sequencer #(.N(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .din(din), .shamt(shamt),
    .cin(cin), .ready(ready), .busy(busy), .done(done), .dout(dout), .cout(cout)
  );

  always #5 clk = ~clk;

  // Reference model written arithmetically rather than step-by-step.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] d,
                                 input logic [4:0] s, input logic c);
    exp_t        e;
    logic [63:0] t;
    int          sh;
    sh    = int'(s);
    e.d   = d;
    e.c   = c;
    e.lat = 1;
    if (o == 3'b110) begin
      e.d   = {c, d[31:1]};
      e.c   = d[0];
      e.lat = 2;
    end else if ((o == 3'b001 || o == 3'b010 || o == 3'b011 || o == 3'b101) && sh != 0) begin
      case (o)
        3'b001: begin e.d = d << sh; e.c = d[32-sh]; end
        3'b010: begin e.d = d >> sh; e.c = d[sh-1]; end
        3'b011: begin e.d = $signed(d) >>> sh; e.c = d[sh-1]; end
        default: begin t = {d, d} >> sh; e.d = t[31:0]; e.c = d[sh-1]; end
      endcase
`ifdef SHIFT_SEQ_DUAL_STEP_EN
      e.lat = (sh + 1) / 2 + 1;
`else
      e.lat = sh + 1;
`endif
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; drives one request and returns one negedge after acceptance.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] d,
                               input logic [4:0] s, input logic c);
    int guard = 0;
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    op    = o;
    din   = d;
    shamt = s;
    cin   = c;
    sb.push_back(model(o, d, s, c));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int n0, input string tag);
    int   n;
    exp_t e;
    n = n0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_lat"}, 32'(n), 32'(e.lat));
    checkOutput({tag, "_dout"}, dout, e.d);
    checkOutput({tag, "_cout"}, 32'(cout), 32'(e.c));
    checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    din   = 32'd0;
    shamt = 5'd0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_dout", dout, 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] LSL by 1");
    applyStimulus(3'b001, 32'h8000_0001, 5'd1, 1'b0);
    checkOutput("lsl1_busy", 32'(busy), 32'd1);
    checkOutput("lsl1_ready", 32'(ready), 32'd0);
    waitDone(1, "lsl1");
    checkOutput("lsl1_dout_const", dout, 32'h0000_0002);
    checkOutput("lsl1_cout_const", 32'(cout), 32'd1);
    @(negedge clk);
    checkOutput("lsl1_done_pulse", 32'(done), 32'd0);

    $display("[TB] ASR by 4");
    applyStimulus(3'b011, 32'h8000_0000, 5'd4, 1'b1);
    waitDone(1, "asr4");
    checkOutput("asr4_dout_const", dout, 32'hF800_0000);
    checkOutput("asr4_cout_const", 32'(cout), 32'd0);
    @(negedge clk);

    $display("[TB] ROR by 31 with ignored mid-op start");
    applyStimulus(3'b101, 32'h0000_0001, 5'd31, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("ror_busy_mid", 32'(busy), 32'd1);
    start = 1'b1;
    op    = 3'b001;
    din   = 32'hFFFF_FFFF;
    shamt = 5'd3;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    din   = 32'h5555_5555;
    waitDone(6, "ror31");
    checkOutput("ror31_dout_const", dout, 32'h0000_0002);
    checkOutput("ror31_cout_const", 32'(cout), 32'd0);
    @(negedge clk);
    checkOutput("ror31_idle_after", 32'(done), 32'd0);

    $display("[TB] RRX");
    applyStimulus(3'b110, 32'h0000_0003, 5'd7, 1'b1);
    waitDone(1, "rrx");
    checkOutput("rrx_dout_const", dout, 32'h8000_0001);
    checkOutput("rrx_cout_const", 32'(cout), 32'd1);
    @(negedge clk);

    $display("[TB] LSR by 0 then back-to-back ASR");
    applyStimulus(3'b010, 32'h1234_5678, 5'd0, 1'b1);
    waitDone(1, "lsr0");
    checkOutput("lsr0_dout_const", dout, 32'h1234_5678);
    applyStimulus(3'b011, 32'hF000_000F, 5'd2, 1'b0);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    waitDone(1, "b2b_asr");
    applyStimulus(3'b100, 32'hCAFE_F00D, 5'd9, 1'b0);
    waitDone(1, "pass100");
    @(negedge clk);

    $display("[TB] reset during LSL by 20");
    applyStimulus(3'b001, 32'hDEAD_BEEF, 5'd20, 1'b1);
    repeat (4) begin
      checkOutput("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_front());
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_dout", dout, 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    checkOutput("abort_idle_done", 32'(done), 32'd0);
    applyStimulus(3'b001, 32'h0000_00FF, 5'd8, 1'b0);
    waitDone(1, "post_abort");
    @(negedge clk);

    $display("[TB] random operations");
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ro;
      case ($urandom_range(0, 5))
        0: ro = 3'b001;
        1: ro = 3'b010;
        2: ro = 3'b011;
        3: ro = 3'b101;
        4: ro = 3'b110;
        default: ro = 3'b111;
      endcase
      applyStimulus(ro, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      waitDone(1, $sformatf("rand%0d", i));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that sequences one-bit shift/rotate steps for the CPU's shifter operand path. It accepts a request (operation, data, amount, carry-in) through a start/ready handshake and iterates one bit per clock. It returns the result and the ARM-style shifter carry-out with a one-cycle done pulse. It sits between the instruction decode/control unit and the ALU operand-2 input, and replaces a full barrel shifter where area matters more than latency.

## Interface
- N, 32, datapath width; N ≥ 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only when ready=1
- op  in  3  000 pass, 001 LSL, 010 LSR, 011 ASR, 101 ROR, 110 RRX; 100/111 treated as pass
- din  in  N  operand to shift
- shamt  in  5  shift amount 0–31 (ignored for RRX)
- cin  in  1  carry flag in (RRX fill bit; carry-out when no shift occurs)
- ready  out  1  high in IDLE and DONE; request can be accepted
- busy  out  1  high in SHIFT
- done  out  1  one-cycle pulse, result valid
- dout  out  N  result; held stable until the next accepted start
- cout  out  1  shifter carry-out; held with dout

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset → IDLE, dout=0, cout=0, done=0, busy=0, ready=1.
- Accept (ready & start): latch op, shamt, cin; load work register with din; count ← shamt.
  - Go to DONE directly if op is pass or an unused code, or if shamt=0 and op≠RRX. Then dout=din and cout=cin.
  - Otherwise go to SHIFT. RRX forces count=1.
- SHIFT, per edge, one step on the work register and the carry:
  - LSL: cout ← w[N-1]; w ← {w[N-2:0],0}.
  - LSR: cout ← w[0]; w ← {0,w[N-1:1]}.
  - ASR: cout ← w[0]; w ← {w[N-1],w[N-1:1]}.
  - ROR: cout ← w[0]; w ← {w[0],w[N-1:1]}.
  - RRX: cout ← w[0]; w ← {cin_latched,w[N-1:1]}.
  - count ← count−1. When count=1 at the step, move to DONE after that step.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or a new acceptance if start=1 (back-to-back accepted).
- start while busy=1 is ignored. It is not queued, and latched operands are not disturbed.
- Input changes while busy have no effect.
- reset in any state aborts the operation. No done is issued, and outputs return to reset values on that edge.
- dout/cout update only on the DONE transition path. In SHIFT, dout keeps its previous value.

## Timing
- Start sampled at edge 0.
- Shift ops: done high in the cycle after edge shamt, i.e. latency shamt+1 cycles (shamt ≥ 1).
- Pass or shamt=0: done in the cycle after edge 0 (latency 1).
- RRX: latency 2.
- ready falls the cycle after acceptance of a shifting op, and rises with done.
- Throughput: one request per latency cycles; the DONE cycle overlaps the next acceptance.

## Configuration
- SHIFT_SEQ_DUAL_STEP_EN defined: in SHIFT, if count ≥ 2, perform two one-bit steps per edge.
  - Carry is taken from the second step; count decrements by 2.
  - With count=1, a single step is performed.
  - Latency becomes ceil(shamt/2)+1. RRX is unchanged (2).
- Undefined: strictly one step per edge as above. Results and carry are identical in both builds; only latency differs.

## Test plan
- LSL, din=0x8000_0001, shamt=1, cin=0 → done 2 cycles after start, dout=0x0000_0002, cout=1.
- ASR, din=0x8000_0000, shamt=4 → dout=0xF800_0000, cout=0, latency 5 (3 with SHIFT_SEQ_DUAL_STEP_EN).
- ROR, din=0x0000_0001, shamt=31 → dout=0x0000_0002, cout=0, latency 32 (17 dual-step). A start pulse mid-operation with different operands is ignored, and the result is unchanged.
- RRX, din=0x0000_0003, cin=1, shamt=7 → dout=0x8000_0001, cout=1, latency 2.
- LSR, shamt=0, din=0x1234_5678, cin=1 → latency 1, dout=0x1234_5678, cout=1. An immediate back-to-back start in the DONE cycle is accepted.
- LSL, shamt=20, reset asserted 5 cycles after start → no done; next cycle ready=1, dout=0, cout=0. A following request completes normally.
